mont_bench_scheduler: RTL
=========================

// Module: mont_bench_scheduler
// PURPOSE
//  UART-command-driven sequencer for the montgomery_unit benchmark datapath.
//  Parses a 9-byte RUN command from the UART RX byte stream and loads the seed and iteration count.
//  Iterates a <= mont_a_out + 1 for N rounds, honouring the datapath latency.
//  Streams the 32-bit result, plus an optional cycle count, back through the UART TX handshake.
//  Sits between uart_rx_simple/uart_tx_simple and montgomery_unit in the benchmark top.
// PARAMETERS
//  MONT_LAT    1        cycles from mont_a_in valid to mont_a_out valid (0 = combinational)
//  RX_TIMEOUT  2700000  max clk cycles between argument bytes before abort (100 ms @27 MHz)
//  ERR_BYTE    8'hEE    single-byte reply to an unknown opcode
// PORTS
//  clk         in   1   system clock
//  rst         in   1   asynchronous, active-high reset
//  rx_data     in   8   received byte, valid while rx_ready=1
//  rx_ready    in   1   one-cycle strobe per received byte
//  tx_data     out  8   byte to transmit
//  tx_start    out  1   one-cycle transmit request
//  tx_busy     in   1   transmitter busy
//  mont_a_in   out  32  operand to montgomery_unit (equals internal register a)
//  mont_a_out  in   32  montgomery_unit result
//  busy        out  1   high in RX_ARGS, COMPUTE and TX states (drives LED)
//  done        out  1   one-cycle pulse when the last response byte has been handed to TX
// BEHAVIOUR
//  - Reset: asynchronous, active-high.
//    - All outputs are 0. a, iteration count, latency counter, byte index and cycle counter are 0. State is IDLE.
//    - A reset mid-operation aborts immediately. No partial response is completed.
//  - IDLE: waits for rx_ready.
//    - Opcode 8'h01: go to RX_ARGS with byte index 0.
//    - Any other opcode: load tx_data=ERR_BYTE and go to TX_SEND with a 1-byte response.
//  - RX_ARGS: accepts 8 bytes, little-endian.
//    - Bytes 0-3 form the seed and are loaded into a.
//    - Bytes 4-7 form N, the iteration count.
//    - The timeout counter clears on every rx_ready.
//    - When the counter reaches RX_TIMEOUT, return to IDLE silently.
//    - After byte 7, go to COMPUTE on the next cycle.
//  - COMPUTE: the latency counter runs 0..MONT_LAT.
//    - When it equals MONT_LAT: a <= mont_a_out + 1 (mod 2^32), the iteration count increments, and the latency counter clears.
//    - Each iteration takes exactly MONT_LAT+1 cycles.
//    - N=0: leave COMPUTE in its first cycle with a = seed unchanged.
//    - When the iteration count equals N, go to TX_SEND with byte index 0.
//  - TX_SEND: waits for !tx_busy, then drives tx_data and pulses tx_start for 1 cycle.
//    - Bytes go out in the order a[7:0], a[15:8], a[23:16], a[31:24].
//  - TX_HOLD: one guard cycle (tx_start=0) to absorb the busy-assert latency.
//  - TX_WAIT: waits for !tx_busy.
//    - If more bytes remain, go back to TX_SEND.
//    - Otherwise pulse done and go to IDLE.
//  - rx_ready in COMPUTE or any TX state is dropped. Bytes are not queued.
//  - The iteration count and N compare as 32-bit unsigned values. N=32'hFFFFFFFF is legal and does not wrap early.
//  - tx_start is never high on two consecutive cycles.
//  - tx_data is held stable from the tx_start pulse until the next TX_SEND.
// CONFIGURATION
//  CYCLE_COUNT_EN defined:
//    - A 32-bit cycle counter clears on entry to COMPUTE and increments on every COMPUTE cycle. It saturates at 32'hFFFFFFFF.
//    - The response becomes 8 bytes: 4 result bytes, then 4 count bytes LSB first.
//  CYCLE_COUNT_EN undefined:
//    - No counter is implemented. The response is 4 result bytes only.
// TESTING  (stub datapath: mont_a_out = mont_a_in after MONT_LAT cycles; MONT_LAT=1)
//  - Reset, no RX traffic -> all outputs 0, busy=0, tx_start never pulses.
//  - RX 01 05 00 00 00 03 00 00 00 -> TX 08 00 00 00; +06 00 00 00 with CYCLE_COUNT_EN; one done pulse.
//  - RX 01 FF FF FF FF 00 00 00 00 (N=0) -> TX FF FF FF FF; count 00 00 00 00.
//  - RX 01 then 2 bytes then idle > RX_TIMEOUT -> no TX; a following full RUN completes normally.
//  - RX 7A -> TX single EE. tx_busy held high 500 cycles -> tx_start waits, then exactly one pulse.
//  - Assert rst while in COMPUTE (N=1000) -> busy=0 immediately; no tx_start until a new command.

Source files
------------

// File: rtl/mont_bench_scheduler.sv
// UART-command sequencer for the montgomery_unit benchmark: parses RUN, iterates a <= f(a)+1 N times, returns the result.
// Optional macro CYCLE_COUNT_EN appends a saturating 32-bit COMPUTE cycle count to the response.
module mont_bench_scheduler #(
  parameter int         MONT_LAT   = 1,
  parameter int         RX_TIMEOUT = 2700000,
  parameter logic [7:0] ERR_BYTE   = 8'hEE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [31:0] mont_a_in,
  input  logic [31:0] mont_a_out,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] LAT = 32'(MONT_LAT);
  localparam logic [31:0] TMO = 32'(RX_TIMEOUT);
`ifdef CYCLE_COUNT_EN
  localparam logic [3:0]  RESP_BYTES = 4'd8;
`else
  localparam logic [3:0]  RESP_BYTES = 4'd4;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_RX_ARGS, S_COMPUTE, S_TX_SEND, S_TX_HOLD, S_TX_WAIT
  } state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_n;
  logic [31:0] r_iter;
  logic [31:0] r_lat;
  logic [31:0] r_tmo;
  logic [3:0]  r_idx;
  logic        r_err;
  logic [7:0]  r_tx_data;
  logic        r_tx_start;
  logic        r_done;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [3:0]  w_n_bytes;

`ifdef CYCLE_COUNT_EN
  logic [31:0] r_cyc;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

  // Response byte selection: result bytes first, then (optionally) count bytes, LSB first
  always_comb begin
    w_word = r_a;
`ifdef CYCLE_COUNT_EN
    if (r_idx[2]) w_word = r_cyc;
`endif
    w_byte    = r_err ? ERR_BYTE : w_word[{r_idx[1:0], 3'b000} +: 8];
    w_n_bytes = r_err ? 4'd1 : RESP_BYTES;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_n        <= '0;
      r_iter     <= '0;
      r_lat      <= '0;
      r_tmo      <= '0;
      r_idx      <= '0;
      r_err      <= 1'b0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
`ifdef CYCLE_COUNT_EN
      r_cyc      <= '0;
`endif
    end else begin
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_ready) begin
            r_idx <= '0;
            if (rx_data == 8'h01) begin
              r_err   <= 1'b0;
              r_tmo   <= '0;
              r_state <= S_RX_ARGS;
            end else begin
              r_err     <= 1'b1;
              r_tx_data <= ERR_BYTE;
              r_state   <= S_TX_SEND;
            end
          end
        end
        S_RX_ARGS: begin
          if (rx_ready) begin
            r_tmo <= '0;
            if (!r_idx[2]) r_a[{r_idx[1:0], 3'b000} +: 8] <= rx_data;
            else           r_n[{r_idx[1:0], 3'b000} +: 8] <= rx_data;
            if (r_idx == 4'd7) begin
              r_iter  <= '0;
              r_lat   <= '0;
`ifdef CYCLE_COUNT_EN
              r_cyc   <= '0;
`endif
              r_state <= S_COMPUTE;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end else if (r_tmo == TMO) begin
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 32'd1;
          end
        end
        // The exit test comes first so N=0 leaves with the seed untouched and no cycles counted
        S_COMPUTE: begin
          if (r_iter == r_n) begin
            r_idx   <= '0;
            r_state <= S_TX_SEND;
          end else begin
`ifdef CYCLE_COUNT_EN
            r_cyc <= sat_inc(r_cyc);
`endif
            if (r_lat == LAT) begin
              r_a    <= mont_a_out + 32'd1;
              r_iter <= r_iter + 32'd1;
              r_lat  <= '0;
            end else begin
              r_lat <= r_lat + 32'd1;
            end
          end
        end
        S_TX_SEND: begin
          if (!tx_busy) begin
            r_tx_data  <= w_byte;
            r_tx_start <= 1'b1;
            r_idx      <= r_idx + 4'd1;
            r_state    <= S_TX_HOLD;
          end
        end
        // Guard cycle: the transmitter raises busy one cycle after the start strobe
        S_TX_HOLD: r_state <= S_TX_WAIT;
        S_TX_WAIT: begin
          if (!tx_busy) begin
            if (r_idx == w_n_bytes) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_TX_SEND;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_start  = r_tx_start;
  assign mont_a_in = r_a;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule
